// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared SRAM read/write path definitions: word geometry and
//                the byte-parity convention used by generator and checker.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_pkg;

    localparam int unsigned SRAM_DATA_W = 32;
    localparam int unsigned SRAM_NPAR   = SRAM_DATA_W / 8;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

    // Stored parity bit for one byte; the write-path generator calls the same
    // function so both sides can never disagree on the convention.
    function automatic logic byte_parity(input logic [7:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage : sram_pkg
`default_nettype wire

// File: rtl/parity_byte.sv
`default_nettype none
// ============================================================================
//  Module      : parity_byte
//  Description : Expected parity bit of one byte (XOR reduction plus mode).
//  Revision    : 1.0  initial release
// ============================================================================
module parity_byte
    import sram_pkg::*;
#(
    parameter bit ODD_PARITY = PARITY_EVEN
) (
    input  logic [7:0] data,
    output logic       parity
);

    always_comb begin
        parity = byte_parity(data, ODD_PARITY);
    end

endmodule : parity_byte
`default_nettype wire

// File: rtl/parity_check.sv
`default_nettype none
// ============================================================================
//  Module      : parity_check
//  Description : Registered per-byte parity check of SRAM read data with
//                sticky error flag and saturating error counter.
//  Revision    : 1.0  initial release
// ============================================================================
module parity_check
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W     = SRAM_DATA_W,
    parameter int unsigned NPAR       = DATA_W / 8,
    parameter bit          ODD_PARITY = PARITY_EVEN,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data,
    input  logic [NPAR-1:0]   parity_bits,
    input  logic              clear,
    output logic              out_valid,
    output logic              error_flag,
    output logic [NPAR-1:0]   byte_err,
    output logic              sticky_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NPAR-1:0]  exp_par;
    logic [NPAR-1:0]  mis;
    logic             word_err;

    logic             out_valid_d,  out_valid_q;
    logic             error_flag_d, error_flag_q;
    logic [NPAR-1:0]  byte_err_d,   byte_err_q;
    logic             sticky_err_d, sticky_err_q;
    logic [CNT_W-1:0] err_count_d,  err_count_q;

    for (genvar i = 0; i < NPAR; i++) begin : g_byte
        parity_byte #(
            .ODD_PARITY (ODD_PARITY)
        ) u_parity_byte (
            .data   (data[8*i +: 8]),
            .parity (exp_par[i])
        );
    end

    always_comb begin
        mis      = exp_par ^ parity_bits;
        word_err = in_valid & (|mis);

        out_valid_d  = in_valid;
        error_flag_d = word_err;
        // Invalid cycles report a clean result so stale errors never leak out.
        byte_err_d   = in_valid ? mis : '0;

        // Clear has priority over a same-cycle error for the diagnostic state,
        // while the per-word outputs above still report that error.
        sticky_err_d = sticky_err_q;
        err_count_d  = err_count_q;
        if (clear) begin
            sticky_err_d = 1'b0;
            err_count_d  = '0;
        end else if (word_err) begin
            sticky_err_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            error_flag_q <= 1'b0;
            byte_err_q   <= '0;
            sticky_err_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            error_flag_q <= error_flag_d;
            byte_err_q   <= byte_err_d;
            sticky_err_q <= sticky_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign error_flag = error_flag_q;
    assign byte_err   = byte_err_q;
    assign sticky_err = sticky_err_q;
    assign err_count  = err_count_q;

endmodule : parity_check
`default_nettype wire

// File: tb/tb_parity_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_check
//  Description : Directed table-driven bench for parity_check (even, odd and
//                narrow-counter instances sharing one stimulus).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parity_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] data;
    logic [3:0]  parity_bits;
    logic        clear;

    logic        ov,   ef,   se;
    logic [3:0]  be;
    logic [15:0] cnt;
    logic        ov_o, ef_o, se_o;
    logic [3:0]  be_o;
    logic [15:0] cnt_o;
    logic        ov_s, ef_s, se_s;
    logic [3:0]  be_s;
    logic [1:0]  cnt_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parity_check dut (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .data (data),
        .parity_bits (parity_bits), .clear (clear), .out_valid (ov),
        .error_flag (ef), .byte_err (be), .sticky_err (se), .err_count (cnt)
    );

    parity_check #(.ODD_PARITY(1'b1)) dut_odd (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .data (data),
        .parity_bits (parity_bits), .clear (clear), .out_valid (ov_o),
        .error_flag (ef_o), .byte_err (be_o), .sticky_err (se_o), .err_count (cnt_o)
    );

    parity_check #(.CNT_W(2)) dut_sat (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .data (data),
        .parity_bits (parity_bits), .clear (clear), .out_valid (ov_s),
        .error_flag (ef_s), .byte_err (be_s), .sticky_err (se_s), .err_count (cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] p, input logic c);
        @(negedge clk);
        in_valid    = v;
        data        = d;
        parity_bits = p;
        clear       = c;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  p;
        logic        clr;
        logic        e_err;
        logic [3:0]  e_byte;
        logic        e_sticky;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFFF, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 16'd1};
        tbl[2]  = '{1'b1, 32'h0103_0700, 4'b1001, 1'b0, 1'b1, 4'b0011, 1'b1, 16'd2};
        tbl[3]  = '{1'b1, 32'h0103_0700, 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b1, 16'd2};
        tbl[4]  = '{1'b0, 32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 16'd2};
        tbl[5]  = '{1'b1, 32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 32'h8000_0001, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 32'h1234_5678, 4'b1011, 1'b0, 1'b1, 4'b1111, 1'b1, 16'd1};
        tbl[8]  = '{1'b1, 32'hFFFF_FFFC, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 16'd1};
        tbl[9]  = '{1'b0, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[10] = '{1'b1, 32'h0000_0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 16'd1};

        rst_n = 1'b1; in_valid = 1'b0; data = '0; parity_bits = '0; clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid",  {31'd0, ov},  32'd0);
        check("reset error_flag", {31'd0, ef},  32'd0);
        check("reset byte_err",   {28'd0, be},  32'd0);
        check("reset sticky_err", {31'd0, se},  32'd0);
        check("reset err_count",  {16'd0, cnt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].clr);
            check($sformatf("v%0d out_valid", i),  {31'd0, ov},  {31'd0, tbl[i].v});
            check($sformatf("v%0d error_flag", i), {31'd0, ef},  {31'd0, tbl[i].e_err});
            check($sformatf("v%0d byte_err", i),   {28'd0, be},  {28'd0, tbl[i].e_byte});
            check($sformatf("v%0d sticky_err", i), {31'd0, se},  {31'd0, tbl[i].e_sticky});
            check($sformatf("v%0d err_count", i),  {16'd0, cnt}, {16'd0, tbl[i].e_cnt});
            // Odd mode inverts every expected bit, so valid words flip every mismatch.
            check($sformatf("v%0d odd byte_err", i), {28'd0, be_o},
                  {28'd0, tbl[i].v ? ~tbl[i].e_byte : 4'b0000});
        end

        // Narrow counter: zero it, then five bad words must saturate at 3.
        drive(1'b0, 32'h0, 4'b0000, 1'b1);
        check("sat cleared", {30'd0, cnt_s}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 32'hFFFF_FFFF, 4'b0001, 1'b0);
            check($sformatf("sat word%0d err_count", k), {30'd0, cnt_s}, (k < 3) ? k : 3);
        end
        check("sat error_flag", {31'd0, ef_s}, 32'd1);

        // Asynchronous reset mid-stream, checked before the next clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid",  {31'd0, ov_s},  32'd0);
        check("async rst error_flag", {31'd0, ef_s},  32'd0);
        check("async rst byte_err",   {28'd0, be_s},  32'd0);
        check("async rst sticky_err", {31'd0, se_s},  32'd0);
        check("async rst err_count",  {30'd0, cnt_s}, 32'd0);
        check("async rst count16",    {16'd0, cnt},   32'd0);
        @(posedge clk);
        #1;
        check("held rst error_flag", {31'd0, ef_s}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; data = 32'hFFFF_FFFF; parity_bits = 4'b0000; clear = 1'b0;
        @(posedge clk);
        #1;
        check("post rst out_valid",  {31'd0, ov_s},  32'd1);
        check("post rst error_flag", {31'd0, ef_s},  32'd0);
        check("post rst err_count",  {30'd0, cnt_s}, 32'd0);
        drive(1'b1, 32'hFFFF_FFFF, 4'b0100, 1'b0);
        check("post rst bad byte_err",  {28'd0, be_s},  32'h4);
        check("post rst bad err_count", {30'd0, cnt_s}, 32'd1);
        check("post rst bad sticky",    {31'd0, se_s},  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_parity_check
`default_nettype wire
